mtimer: RTL and testbench

- Machine timer peripheral directly upstream of the CSR/interrupt unit.
- Holds a free-running 64-bit mtime and a 64-bit mtimecmp, both memory-mapped on the 32-bit data bus.
- Drives the active-low timer interrupt line `ti` consumed by the CSR block (mip[7]/mcause 0x80000007 path).

---
 rtl/mtimer.sv | 164 ++++++++++++++++
 tb/tb_mtimer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// mtimer: machine timer peripheral feeding the CSR/interrupt unit.
//
// Holds a free-running 64-bit mtime and a 64-bit mtimecmp, both mapped onto
// a 32-bit bus, and drives the active-low, level-sensitive interrupt ti.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   cs     in   chip select, active low (masks we and re)
//   we     in   write strobe, active low
//   re     in   read strobe, active low
//   addr   in   [4:0] byte address, bits [1:0] ignored
//   wdata  in   [31:0] write data
//   rdata  out  [31:0] registered read data, held until the next read
//   ti     out  registered timer interrupt, active low
//
// Register map (word offsets):
//   0x00 MTIME_LO   0x04 MTIME_HI (reads hi_shadow latched by a MTIME_LO read)
//   0x08 MTIMECMP_LO   0x0C MTIMECMP_HI
//   0x10 CTRL: bit0 EN, bit1 PEND (= ~ti, read-only)
//   0x14 PRESCALE (only when MTIMER_PRESCALE_EN is defined)
//
// Build option: define MTIMER_PRESCALE_EN to add the prescaler; mtime then
// advances once every PRESCALE+1 clocks while EN=1.

module mtimer #(
  parameter logic [63:0] RESET_CMP  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic        re,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ti
);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ti_q, ti_d;

  logic        wr_en, rd_en, tick;
  logic [2:0]  word;
  logic        unused_addr;

  assign wr_en       = ~cs & ~we;
  assign rd_en       = ~cs & ~re;
  assign word        = addr[4:2];
  assign unused_addr = ^addr[1:0];

`ifdef MTIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  assign tick = en_q && (pcnt_q == prescale_q);

  always_comb begin
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end
    if (wr_en) begin
      case (word)
        OFF_PRESCALE: begin
          prescale_d = wdata[PRESCALE_W-1:0];
          pcnt_d     = '0;
        end
        OFF_MTIME_LO, OFF_MTIME_HI: pcnt_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end
`else
  localparam int unsigned UNUSED_PRESCALE_W = PRESCALE_W;
  assign tick = en_q;
`endif

  always_comb begin
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d       = cmp_q;
    en_d        = en_q;
    hi_shadow_d = hi_shadow_q;
    rdata_d     = rdata_q;

    // A write to either mtime half overrides the increment for the whole
    // 64-bit value, so the untouched half keeps its pre-edge value.
    if (wr_en) begin
      case (word)
        OFF_MTIME_LO: mtime_d = {mtime_q[63:32], wdata};
        OFF_MTIME_HI: mtime_d = {wdata, mtime_q[31:0]};
        OFF_CMP_LO:   cmp_d   = {cmp_q[63:32], wdata};
        OFF_CMP_HI:   cmp_d   = {wdata, cmp_q[31:0]};
        OFF_CTRL:     en_d    = wdata[0];
        default: ;
      endcase
    end

    // Reads sample pre-edge state, so a same-cycle write is not visible.
    if (rd_en) begin
      case (word)
        OFF_MTIME_LO: begin
          rdata_d     = mtime_q[31:0];
          hi_shadow_d = mtime_q[63:32];
        end
        OFF_MTIME_HI: rdata_d = hi_shadow_q;
        OFF_CMP_LO:   rdata_d = cmp_q[31:0];
        OFF_CMP_HI:   rdata_d = cmp_q[63:32];
        OFF_CTRL:     rdata_d = {30'd0, ~ti_q, en_q};
`ifdef MTIMER_PRESCALE_EN
        OFF_PRESCALE: rdata_d = 32'(prescale_q);
`endif
        default:      rdata_d = '0;
      endcase
    end

    ti_d = ~(en_q & (mtime_q >= cmp_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      cmp_q       <= RESET_CMP;
      en_q        <= 1'b0;
      hi_shadow_q <= '0;
      rdata_q     <= '0;
      ti_q        <= 1'b1;
    end else begin
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      en_q        <= en_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      ti_q        <= ti_d;
    end
  end

  assign rdata = rdata_q;
  assign ti    = ti_q;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer. Inputs change on the falling edge; read
// expectations are queued when a read is driven and compared once rdata is
// valid on the following falling edge.

module tb_mtimer;

  logic        clk;
  logic        rst;
  logic        cs, we, re;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ti;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [4:0] A_LO    = 5'h00;
  localparam logic [4:0] A_HI    = 5'h04;
  localparam logic [4:0] A_CLO   = 5'h08;
  localparam logic [4:0] A_CHI   = 5'h0C;
  localparam logic [4:0] A_CTRL  = 5'h10;
  localparam logic [4:0] A_PRE   = 5'h14;
  localparam logic [4:0] A_UNMAP = 5'h18;

  mtimer dut (
    .clk   (clk),
    .rst   (rst),
    .cs    (cs),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ti    (ti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b0; we = 1'b0; re = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b1; we = 1'b1;
  endtask

  task automatic pop_compare();
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, rdata, e);
    end
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] e, input string t);
    cs = 1'b0; re = 1'b0; we = 1'b1; addr = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk);
    cs = 1'b1; re = 1'b1;
    pop_compare();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cs = 1'b1; we = 1'b1; re = 1'b1; addr = '0; wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("ti_reset", {31'd0, ti}, 32'd1);
    check("rdata_reset", rdata, 32'd0);
    bus_read(A_CTRL, 32'h0, "rd_ctrl_reset");
    bus_read(A_LO, 32'h0, "rd_mtime_lo_reset");
    bus_read(A_CHI, 32'hFFFF_FFFF, "rd_cmp_hi_reset");
    idle(2);
    check("rdata_hold", rdata, 32'hFFFF_FFFF);
    check("ti_idle", {31'd0, ti}, 32'd1);

    // cs high masks both strobes
    cs = 1'b1; we = 1'b0; re = 1'b0; addr = A_LO; wdata = 32'h1234;
    @(negedge clk);
    we = 1'b1; re = 1'b1;
    check("cs_mask_no_read", rdata, 32'hFFFF_FFFF);
    bus_read(A_LO, 32'h0, "cs_mask_no_write");

    // Same-cycle read and write returns the pre-write value
    cs = 1'b0; we = 1'b0; re = 1'b0; addr = A_CLO; wdata = 32'hAA;
    exp_q.push_back(32'hFFFF_FFFF);
    tag_q.push_back("rw_same_addr_prewrite");
    @(negedge clk);
    cs = 1'b1; we = 1'b1; re = 1'b1;
    pop_compare();
    bus_read(A_CLO, 32'hAA, "rw_same_addr_after");

    // Unmapped offset
    bus_write(A_UNMAP, 32'h5);
    bus_read(A_UNMAP, 32'h0, "rd_unmapped");

`ifdef MTIMER_PRESCALE_EN
    // PRESCALE=3: mtime advances on every fourth edge after EN rises
    bus_write(A_PRE, 32'd3);
    bus_read(A_PRE, 32'd3, "rd_prescale");
    bus_write(A_CTRL, 32'd1);
    bus_read(A_LO, 32'd0, "prescale_cnt0");
    idle(3);
    bus_read(A_LO, 32'd1, "prescale_cnt1");
    idle(3);
    bus_read(A_LO, 32'd2, "prescale_cnt2");
    idle(3);
    bus_read(A_LO, 32'd3, "prescale_cnt3");
    bus_write(A_CTRL, 32'd0);
    bus_write(A_PRE, 32'd0);
    bus_write(A_LO, 32'd0);
    bus_write(A_HI, 32'd0);
    bus_read(A_LO, 32'd0, "prescale_cleanup");
`else
    bus_write(A_PRE, 32'd7);
    bus_read(A_PRE, 32'h0, "rd_prescale_unmapped");
`endif

    // Compare at 10: ti falls on the edge after mtime reaches 10
    bus_write(A_CHI, 32'd0);
    bus_write(A_CLO, 32'd10);
    check("ti_before_en", {31'd0, ti}, 32'd1);
    bus_write(A_CTRL, 32'd1);
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("ti_count_edge%0d", i), {31'd0, ti}, (i >= 11) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    bus_read(A_CTRL, 32'h3, "rd_ctrl_pend");

    // Coherent 64-bit read across the low-word wrap
    bus_write(A_LO, 32'hFFFF_FFFE);
    bus_write(A_HI, 32'h0);
    idle(2);
    bus_read(A_LO, 32'h0, "wrap_lo");
    idle(5);
    bus_read(A_HI, 32'h1, "wrap_hi_shadow");
    bus_write(A_HI, 32'h55);
    bus_read(A_HI, 32'h1, "hi_shadow_not_live");

    // Write beats the increment on its own edge
    bus_write(A_LO, 32'h100);
    bus_read(A_LO, 32'h100, "write_no_inc");
    idle(3);
    bus_read(A_LO, 32'h104, "write_then_count");

    // Raising mtimecmp to all-ones releases ti one edge later
    check("ti_asserted", {31'd0, ti}, 32'd0);
    bus_write(A_CLO, 32'hFFFF_FFFF);
    bus_write(A_CHI, 32'hFFFF_FFFF);
    check("ti_still_low", {31'd0, ti}, 32'd0);
    @(posedge clk);
    #1;
    check("ti_released", {31'd0, ti}, 32'd1);
    @(negedge clk);

    // Reset during a read aborts it
    cs = 1'b0; re = 1'b0; addr = A_LO;
    #2 rst = 1'b1;
    #1;
    check("rst_async_rdata", rdata, 32'd0);
    @(negedge clk);
    cs = 1'b1; re = 1'b1;
    check("rst_mid_read_rdata", rdata, 32'd0);
    check("rst_mid_read_ti", {31'd0, ti}, 32'd1);
    rst = 1'b0;
    bus_read(A_LO, 32'h0, "post_rst_mtime");
    bus_read(A_CTRL, 32'h0, "post_rst_ctrl");
    bus_read(A_CHI, 32'hFFFF_FFFF, "post_rst_cmp_hi");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
